// File: rtl/bp_gshare_ctrl.sv
// bp_gshare_ctrl: gshare GHR/index control plus a training-update FIFO draining onto the PHT update port.
// Optional BP_PERF_CNT_EN adds saturating prediction/mispredict/drop counters.
module bp_gshare_ctrl #(
  parameter int INDEX_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pred_req_i,
  input  logic [31:0]            pred_pc_i,
  output logic [INDEX_WIDTH-1:0] pht_rd_index_o,
  input  logic                   pht_prediction_i,
  output logic                   pred_taken_o,
  output logic [INDEX_WIDTH-1:0] pred_ghr_o,
  input  logic                   resolve_valid_i,
  input  logic [31:0]            resolve_pc_i,
  input  logic [INDEX_WIDTH-1:0] resolve_ghr_i,
  input  logic                   resolve_taken_i,
  input  logic                   resolve_mispredict_i,
  input  logic                   freeze_i,
  output logic                   pht_update_en_o,
  output logic [INDEX_WIDTH-1:0] pht_update_index_o,
  output logic                   pht_br_taken_o,
  output logic                   fifo_full_o
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_pred_cnt_o,
  output logic [31:0]            perf_mispred_cnt_o,
  output logic [31:0]            perf_drop_cnt_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [INDEX_WIDTH-1:0] ghr_q, ghr_d, resolve_idx;
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic [INDEX_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [INDEX_WIDTH:0] head;
  logic empty, full, deq, enq, mispred, unused_pc;
  assign unused_pc = ^{pred_pc_i[31:INDEX_WIDTH+2], pred_pc_i[1:0],
                       resolve_pc_i[31:INDEX_WIDTH+2], resolve_pc_i[1:0]};
  assign mispred        = resolve_valid_i & resolve_mispredict_i;
  assign resolve_idx    = resolve_pc_i[INDEX_WIDTH+1:2] ^ resolve_ghr_i;
  assign pht_rd_index_o = pred_pc_i[INDEX_WIDTH+1:2] ^ ghr_q;
  assign pred_taken_o   = pht_prediction_i;
  assign pred_ghr_o     = ghr_q;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign deq   = !empty & !freeze_i;
  // At full, a same-cycle dequeue frees the head slot that the write reuses
  assign enq   = resolve_valid_i & (!full | deq);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];
  assign pht_update_en_o    = deq;
  assign pht_update_index_o = empty ? '0 : head[INDEX_WIDTH:1];
  assign pht_br_taken_o     = !empty & head[0];
  assign fifo_full_o        = full;
  always_comb begin
    ghr_d = mispred    ? {resolve_ghr_i[INDEX_WIDTH-2:0], resolve_taken_i} :
            pred_req_i ? {ghr_q[INDEX_WIDTH-2:0], pht_prediction_i} : ghr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      ghr_q    <= ghr_d;
      wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, enq};
      rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, deq};
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q[PW-1:0]] <= {resolve_idx, resolve_taken_i};
  end
`ifdef BP_PERF_CNT_EN
  logic drop;
  assign drop = resolve_valid_i & full & !deq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_pred_cnt_o    <= '0;
      perf_mispred_cnt_o <= '0;
      perf_drop_cnt_o    <= '0;
    end else begin
      perf_pred_cnt_o    <= perf_pred_cnt_o    + {31'b0, pred_req_i & ~&perf_pred_cnt_o};
      perf_mispred_cnt_o <= perf_mispred_cnt_o + {31'b0, mispred & ~&perf_mispred_cnt_o};
      perf_drop_cnt_o    <= perf_drop_cnt_o    + {31'b0, drop & ~&perf_drop_cnt_o};
    end
  end
`endif
endmodule

// File: tb/tb_bp_gshare_ctrl.sv
// tb_bp_gshare_ctrl: directed stimulus with a scoreboard of expected PHT training updates.
module tb_bp_gshare_ctrl;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic pred_req_i = 0, pht_prediction_i = 0, resolve_valid_i = 0, resolve_taken_i = 0;
  logic resolve_mispredict_i = 0, freeze_i = 0;
  logic [31:0] pred_pc_i = 32'h40, resolve_pc_i = 0;
  logic [7:0] resolve_ghr_i = 0;
  logic [7:0] pht_rd_index_o, pred_ghr_o, pht_update_index_o;
  logic pred_taken_o, pht_update_en_o, pht_br_taken_o, fifo_full_o;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_pred_cnt_o, perf_mispred_cnt_o, perf_drop_cnt_o;
`endif
  int checks = 0, errors = 0;
  logic [8:0] sb [$];

  bp_gshare_ctrl #(.INDEX_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
    .pht_rd_index_o(pht_rd_index_o), .pht_prediction_i(pht_prediction_i),
    .pred_taken_o(pred_taken_o), .pred_ghr_o(pred_ghr_o), .resolve_valid_i(resolve_valid_i),
    .resolve_pc_i(resolve_pc_i), .resolve_ghr_i(resolve_ghr_i), .resolve_taken_i(resolve_taken_i),
    .resolve_mispredict_i(resolve_mispredict_i), .freeze_i(freeze_i),
    .pht_update_en_o(pht_update_en_o), .pht_update_index_o(pht_update_index_o),
    .pht_br_taken_o(pht_br_taken_o), .fifo_full_o(fifo_full_o)
`ifdef BP_PERF_CNT_EN
    , .perf_pred_cnt_o(perf_pred_cnt_o), .perf_mispred_cnt_o(perf_mispred_cnt_o),
    .perf_drop_cnt_o(perf_drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_req_i = 0; pht_prediction_i = 0; resolve_valid_i = 0;
    resolve_mispredict_i = 0; resolve_taken_i = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m,
                         input logic accept);
    resolve_valid_i = 1; resolve_pc_i = pc; resolve_ghr_i = g;
    resolve_taken_i = t; resolve_mispredict_i = m;
    if (accept) sb.push_back({pc[9:2] ^ g, t});
  endtask

  // Monitor: every update the DUT issues must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_ni && pht_update_en_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: got idx 0x%0h taken %0b, none expected",
                 pht_update_index_o, pht_br_taken_o);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({pht_update_index_o, pht_br_taken_o} !== e) begin
          errors++;
          $display("FAIL update_order: got idx 0x%0h taken %0b expected idx 0x%0h taken %0b",
                   pht_update_index_o, pht_br_taken_o, e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_en", pht_update_en_o, 0);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_idx", pht_update_index_o, 0);
    chk("rst_taken", pht_br_taken_o, 0);
    chk("rst_ghr", pred_ghr_o, 0);
    chk("rst_rd_index", pht_rd_index_o, 8'h10);
    @(negedge clk); rst_ni = 1;
    tick();
    // Fetch prediction shifts the GHR
    pred_req_i = 1; pred_pc_i = 32'h40; pht_prediction_i = 1;
    #1;
    chk("pred_index", pht_rd_index_o, 8'h10);
    chk("pred_ghr_before", pred_ghr_o, 8'h00);
    chk("pred_taken", pred_taken_o, 1);
    tick(); idle();
    chk("ghr_after_pred", pred_ghr_o, 8'h01);
    chk("pred_index_ghr", pht_rd_index_o, 8'h11);
    // Mispredict repair wins over simultaneous fetch
    pred_req_i = 1; pht_prediction_i = 1;
    resolve(32'h0, 8'h5A, 0, 1, 1);
    tick(); idle();
    chk("ghr_repair", pred_ghr_o, 8'hB4);
    chk("repair_drain_en", pht_update_en_o, 1);
    tick();
    // Single resolve: no bypass, appears next cycle
    resolve(32'h100, 8'h03, 1, 0, 1);
    #1;
    chk("no_bypass", pht_update_en_o, 0);
    tick(); idle();
    chk("upd_en", pht_update_en_o, 1);
    chk("upd_idx", pht_update_index_o, 8'h43);
    chk("upd_taken", pht_br_taken_o, 1);
    tick();
    chk("upd_en_after", pht_update_en_o, 0);
    chk("ghr_hold_on_correct", pred_ghr_o, 8'hB4);
`ifdef BP_PERF_CNT_EN
    chk("perf_pred", perf_pred_cnt_o, 2);
    chk("perf_mispred", perf_mispred_cnt_o, 1);
`endif
    // Frozen fill: fifth resolve dropped
    freeze_i = 1;
    for (int k = 1; k <= 5; k++) begin
      resolve(32'(k) << 2, 8'h00, k[0], 0, k <= 4);
      #1;
      chk("frz_full", fifo_full_o, k == 5);
      chk("frz_en", pht_update_en_o, 0);
      tick();
    end
    idle();
    chk("frz_full_after", fifo_full_o, 1);
`ifdef BP_PERF_CNT_EN
    chk("perf_drop", perf_drop_cnt_o, 1);
`endif
    freeze_i = 0;
    for (int k = 0; k < 4; k++) begin
      #1; chk("thaw_en", pht_update_en_o, 1);
      tick();
    end
    chk("thaw_done_en", pht_update_en_o, 0);
    chk("thaw_done_full", fifo_full_o, 0);
    // Full queue streaming: enqueue+dequeue each cycle, nothing dropped
    freeze_i = 1;
    for (int k = 6; k <= 9; k++) begin
      resolve(32'(k) << 2, 8'h00, k[0], 0, 1);
      tick();
    end
    freeze_i = 0;
    for (int k = 10; k <= 15; k++) begin
      resolve(32'(k) << 2, 8'h00, k[0], 0, 1);
      #1;
      chk("stream_full", fifo_full_o, 1);
      chk("stream_en", pht_update_en_o, 1);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      #1; chk("stream_drain_en", pht_update_en_o, 1);
      tick();
    end
    chk("stream_empty", pht_update_en_o, 0);
`ifdef BP_PERF_CNT_EN
    chk("perf_drop_stream", perf_drop_cnt_o, 1);
`endif
    // Reset mid-drain with 3 entries left
    freeze_i = 1;
    for (int k = 16; k <= 19; k++) begin
      resolve(32'(k) << 2, 8'h00, k[0], 0, 1);
      tick();
    end
    idle(); freeze_i = 0;
    tick();
    #2; rst_ni = 0;
    sb.delete();
    #1;
    chk("midrst_en", pht_update_en_o, 0);
    chk("midrst_full", fifo_full_o, 0);
    chk("midrst_ghr", pred_ghr_o, 0);
    chk("midrst_idx", pht_update_index_o, 0);
    @(negedge clk); rst_ni = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_stale_en", pht_update_en_o, 0);
    end
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
